alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 16-bit ALU between two requesters: port 0 (execute stage) and port 1
//  (secondary user, e.g. address/branch-target generation). Arbitrates, registers the winning
//  operation, drives the ALU control/operand inputs and returns result and flags over a
//  valid/ready response channel tagged with the requester id. One op in flight at a time.
// PARAMETERS
//  WIDTH      16  operand/result width
//  STARVE_MAX 3   max consecutive port-0 grants while port 1 waits (fixed-priority mode only)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      reset, synchronous, active-low
//  reqN_valid   in   1      N=0,1: request present
//  reqN_ready   out  1      N=0,1: request accepted this cycle
//  reqN_a/_b    in   WIDTH  N=0,1: operands A, B
//  reqN_op      in   3      N=0,1: ALU Op (000 rol .. 100 add, 101 sub, 110 xor, 111 andn)
//  reqN_ctl     in   5      N=0,1: {cin, inva, invb, sign, subop}
//  alu_a/_b     out  WIDTH  to ALU A, B
//  alu_op       out  3      to ALU Op
//  alu_ctl      out  5      to ALU {Cin, invA, invB, sign, subOP}
//  alu_out      in   WIDTH  ALU Out
//  alu_flags    in   3      ALU {Ofl, Z, N}
//  rsp_valid    out  1      result available
//  rsp_ready    in   1      consumer accepts result
//  rsp_id       out  1      requester of this result
//  rsp_data     out  WIDTH  registered ALU Out
//  rsp_flags    out  3      registered {Ofl, Z, N}
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, all outputs 0, op/result regs 0, RR pointer=1 (port 0
//    wins first), starve counter 0. Reset mid-op discards the op; no response is produced.
//  - FSM: IDLE -> EXEC on accept; EXEC -> RESP always (1 cycle); RESP -> IDLE on rsp handshake
//    with no accept; RESP -> EXEC on rsp handshake plus same-cycle accept.
//  - Accept window: state==IDLE, or state==RESP && rsp_ready. reqN_ready is combinational,
//    at most one high per cycle, only in accept window and only with reqN_valid high.
//  - On accept: {a,b,op,ctl,id} latched into op reg; alu_* driven from op reg only (stable
//    through EXEC, unchanged in RESP). End of EXEC: alu_out/alu_flags captured into result
//    reg, rsp_valid=1. Latency: accept at edge T -> rsp_valid high after edge T+2.
//    Peak throughput 1 op / 2 cycles.
//  - rsp_valid held with rsp_data/flags/id stable until rsp_ready; no new accept while
//    rsp_valid && !rsp_ready.
//  - Requesters hold valid and payload stable until ready; dropping valid first is legal
//    (withdrawal), changing payload while valid is not.
//  - Round-robin: both valid -> grant port != last granted; one valid -> grant it; pointer
//    updates only on accept.
//  - Flags pass through raw; Ofl meaningful only for add/sub, block does not mask it.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: port 0 strict priority; counter counts port-0 grants while
//    req1_valid; at STARVE_MAX next accept goes to port 1 and counter clears; counter clears on
//    any port-1 grant or when req1_valid is low. RR pointer unused.
//  Not defined: round-robin as above; counter not built.
// TESTING
//  1 rst_n=0 two cycles, reqs valid -> readys 0, rsp_valid 0, alu_a 0, busy 0.
//  2 req0 add 0x0005+0x0003 op=100 ctl=0 -> req0_ready at T, rsp_valid after T+2,
//    data 0x0008, id 0, flags 000.
//  3 req1 sub 0x0003,0x0003 op=101 -> data 0x0000, Z=1; req0 add 0x7FFF+0x0001 sign=1 ->
//    data 0x8000, Ofl=1.
//  4 both valid continuously, rsp_ready=1 -> ids 0,1,0,1, accepts every 2nd cycle.
//  5 rsp_ready=0 for 5 cycles -> rsp_* stable, no ready asserted; release -> next op accepted
//    same cycle.
//  6 ALU_ARB_FIXED_PRIO_EN, STARVE_MAX=3, both valid -> ids 0,0,0,1,0,0,0,1; rst_n low in EXEC
//    -> no rsp_valid.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, ALU-drive and response signals of the shared-ALU arbiter.
// slave = arbiter side, master = requesters, ALU and result consumer.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic [4:0]       req0_ctl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic [4:0]       req1_ctl;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [4:0]       alu_ctl;
  logic [WIDTH-1:0] alu_out;
  logic [2:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req0_op, req0_ctl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    input  req1_op, req1_ctl,
    output req1_ready,
    output alu_a, alu_b, alu_op, alu_ctl,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_id,
    output rsp_data, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req0_op, req0_ctl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    output req1_op, req1_ctl,
    input  req1_ready,
    input  alu_a, alu_b, alu_op, alu_ctl,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_id,
    input  rsp_data, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared 16-bit ALU, one op in flight.
// ALU_ARB_FIXED_PRIO_EN: port 0 priority with starvation limit, else RR.
module alu_arbiter #(
  parameter int WIDTH      = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [4:0]       ctl;
    logic             id;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       flags_q, flags_d;

  logic win;
  logic pick1;
  logic gnt0;
  logic gnt1;
  logic accept;

  // Gated by rst_n so no ready leaks out while reset is held.
  assign win = rst_n &&
    ((state_q == IDLE) ||
     ((state_q == RESP) && bus.rsp_ready));

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q, starve_d;

  assign pick1 = bus.req1_valid &&
    (!bus.req0_valid ||
     (starve_q == CW'(STARVE_MAX)));

  always_comb begin
    starve_d = starve_q;
    if (!bus.req1_valid || gnt1)
      starve_d = '0;
    else if (gnt0)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic rr_q, rr_d;

  // rr_q holds the last granted port.
  assign pick1 = bus.req1_valid &&
    (!bus.req0_valid || !rr_q);

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = gnt1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= 1'b1;
    else        rr_q <= rr_d;
  end
`endif

  assign gnt0   = win && bus.req0_valid && !pick1;
  assign gnt1   = win && pick1;
  assign accept = gnt0 || gnt1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
        data_d  = bus.alu_out;
        flags_d = bus.alu_flags;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case (1'b1)
      gnt0: begin
        op_d.a   = bus.req0_a;
        op_d.b   = bus.req0_b;
        op_d.op  = bus.req0_op;
        op_d.ctl = bus.req0_ctl;
        op_d.id  = 1'b0;
      end
      gnt1: begin
        op_d.a   = bus.req1_a;
        op_d.b   = bus.req1_b;
        op_d.op  = bus.req1_op;
        op_d.ctl = bus.req1_ctl;
        op_d.id  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign bus.alu_a   = op_q.a;
  assign bus.alu_b   = op_q.b;
  assign bus.alu_op  = op_q.op;
  assign bus.alu_ctl = op_q.ctl;

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = op_q.id;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the far side.
// Define ALU_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] exp_ids [8];

  alu_arbiter_if #(.WIDTH(16)) bus ();

  alu_arbiter #(
    .WIDTH(16),
    .STARVE_MAX(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] r;
  logic        ofl;
  logic [3:0]  sh;

  always_comb begin
    r   = '0;
    ofl = 1'b0;
    sh  = bus.alu_b[3:0];
    case (bus.alu_op)
      3'b000: r = (bus.alu_a << sh) | (bus.alu_a >> (5'd16 - {1'b0, sh}));
      3'b001: r = bus.alu_a << sh;
      3'b010: r = (bus.alu_a >> sh) | (bus.alu_a << (5'd16 - {1'b0, sh}));
      3'b011: r = bus.alu_a >> sh;
      3'b100: begin
        r   = bus.alu_a + bus.alu_b;
        ofl = bus.alu_ctl[1] && (bus.alu_a[15] == bus.alu_b[15])
              && (r[15] != bus.alu_a[15]);
      end
      3'b101: begin
        r   = bus.alu_a - bus.alu_b;
        ofl = bus.alu_ctl[1] && (bus.alu_a[15] != bus.alu_b[15])
              && (r[15] != bus.alu_a[15]);
      end
      3'b110: r = bus.alu_a ^ bus.alu_b;
      default: r = bus.alu_a & ~bus.alu_b;
    endcase
  end

  assign bus.alu_out   = r;
  assign bus.alu_flags = {ofl, (r == 16'h0000), r[15]};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set0(input logic v, input logic [15:0] a,
                      input logic [15:0] b, input logic [2:0] op,
                      input logic [4:0] ctl);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_op    = op;
    bus.req0_ctl   = ctl;
  endtask

  task automatic set1(input logic v, input logic [15:0] a,
                      input logic [15:0] b, input logic [2:0] op,
                      input logic [4:0] ctl);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_op    = op;
    bus.req1_ctl   = ctl;
  endtask

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
`else
    exp_ids = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
`endif

    // reset with both requests pending
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b0;
    set0(1'b1, 16'h1111, 16'h2222, 3'b100, 5'd0);
    set1(1'b1, 16'h3333, 16'h4444, 3'b100, 5'd0);
    cyc();
    cyc();
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_alu_a", bus.alu_a, 16'h0);
    chk("rst_busy", busy, 1'b0);

    // port 0 add 5+3
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    set0(1'b1, 16'h0005, 16'h0003, 3'b100, 5'd0);
    set1(1'b0, 16'h0, 16'h0, 3'b000, 5'd0);
    #1;
    chk("add_ready0", bus.req0_ready, 1'b1);
    chk("add_ready1", bus.req1_ready, 1'b0);
    cyc();
    set0(1'b0, 16'h0, 16'h0, 3'b000, 5'd0);
    #1;
    chk("add_exec_busy", busy, 1'b1);
    chk("add_exec_rsp", bus.rsp_valid, 1'b0);
    chk("add_alu_a", bus.alu_a, 16'h0005);
    chk("add_alu_op", bus.alu_op, 3'b100);
    cyc();
    chk("add_rsp_valid", bus.rsp_valid, 1'b1);
    chk("add_data", bus.rsp_data, 16'h0008);
    chk("add_id", bus.rsp_id, 1'b0);
    chk("add_flags", bus.rsp_flags, 3'b000);
    cyc();
    chk("add_idle", busy, 1'b0);

    // port 1 sub 3-3 -> zero
    set1(1'b1, 16'h0003, 16'h0003, 3'b101, 5'b00001);
    #1;
    chk("sub_ready1", bus.req1_ready, 1'b1);
    cyc();
    set1(1'b0, 16'h0, 16'h0, 3'b000, 5'd0);
    cyc();
    chk("sub_rsp_valid", bus.rsp_valid, 1'b1);
    chk("sub_data", bus.rsp_data, 16'h0000);
    chk("sub_flags", bus.rsp_flags, 3'b010);
    chk("sub_id", bus.rsp_id, 1'b1);
    cyc();

    // port 0 signed add overflow
    set0(1'b1, 16'h7FFF, 16'h0001, 3'b100, 5'b00010);
    #1;
    chk("ofl_ready0", bus.req0_ready, 1'b1);
    cyc();
    set0(1'b0, 16'h0, 16'h0, 3'b000, 5'd0);
    cyc();
    chk("ofl_data", bus.rsp_data, 16'h8000);
    chk("ofl_flags", bus.rsp_flags, 3'b101);
    chk("ofl_id", bus.rsp_id, 1'b0);
    cyc();

    // fresh arbitration state, both ports valid continuously
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set0(1'b1, 16'h0001, 16'h0002, 3'b100, 5'd0);
    set1(1'b1, 16'h00F0, 16'h0FF0, 3'b110, 5'd0);
    for (int c = 0; c < 16; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk($sformatf("arb_grant%0d", c / 2),
            {bus.req1_ready, bus.req0_ready},
            (exp_ids[c / 2] == 3'd1) ? 2'b10 : 2'b01);
      end else begin
        chk($sformatf("arb_nogrant%0d", c),
            {bus.req1_ready, bus.req0_ready}, 2'b00);
      end
      if (c >= 2 && c % 2 == 0) begin
        chk($sformatf("arb_rsp_id%0d", c / 2 - 1),
            bus.rsp_id, exp_ids[c / 2 - 1][0]);
        chk($sformatf("arb_rsp_data%0d", c / 2 - 1),
            bus.rsp_data,
            (exp_ids[c / 2 - 1] == 3'd1) ? 16'h0F00 : 16'h0003);
      end
      cyc();
    end

    // backpressure on the last response of the burst
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c),
          {bus.req1_ready, bus.req0_ready}, 2'b00);
      chk($sformatf("bp_valid%0d", c), bus.rsp_valid, 1'b1);
      chk($sformatf("bp_id%0d", c), bus.rsp_id, exp_ids[7][0]);
      chk($sformatf("bp_data%0d", c), bus.rsp_data,
          (exp_ids[7] == 3'd1) ? 16'h0F00 : 16'h0003);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant",
        {bus.req1_ready, bus.req0_ready}, 2'b01);
    cyc();
    set0(1'b0, 16'h0, 16'h0, 3'b000, 5'd0);
    set1(1'b0, 16'h0, 16'h0, 3'b000, 5'd0);
    #1;
    chk("bp_exec_busy", busy, 1'b1);
    chk("bp_exec_rsp", bus.rsp_valid, 1'b0);

    // reset while in EXEC discards the op
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rsp0", bus.rsp_valid, 1'b0);
    cyc();
    chk("midrst_rsp1", bus.rsp_valid, 1'b0);
    cyc();
    chk("midrst_rsp2", bus.rsp_valid, 1'b0);
    chk("midrst_data", bus.rsp_data, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
